// File: rtl/dac714_serial_tx.sv
// Serial transmitter for a DAC714: captures Yis on DACStrobe rise, shifts it MSB-first, pulses nLDAC.
// Optional build macro DAC714_OFFSET_BINARY_EN inverts the word MSB (two's complement -> offset binary).
module dac714_serial_tx #(
  parameter int DAC_WIDTH = 16,
  parameter int CLK_DIV   = 4,
  parameter int LATCH_CYC = 2
) (
  input  logic                 clk,
  input  logic                 nReset,
  input  logic                 DACStrobe,
  input  logic [DAC_WIDTH-1:0] Yis,
  input  logic                 clr_overrun,
  output logic                 dac_sclk,
  output logic                 dac_sdi,
  output logic                 dac_nCS,
  output logic                 dac_nLDAC,
  output logic                 busy,
  output logic [7:0]           overrun_cnt
);

  localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(DAC_WIDTH + 1);
  localparam int LW = (LATCH_CYC > 1) ? $clog2(LATCH_CYC) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_LATCH} state_t;

  state_t               state_q, state_d;
  logic                 strobe_q, strobe_d;
  logic [DAC_WIDTH-1:0] shreg_q, shreg_d;
  logic [HW-1:0]        half_q, half_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [LW-1:0]        lat_q, lat_d;
  logic                 sclk_q, sclk_d;
  logic                 sdi_q, sdi_d;
  logic                 ncs_q, ncs_d;
  logic                 nldac_q, nldac_d;
  logic                 busy_q, busy_d;
  logic                 pend_v_q, pend_v_d;
  logic [DAC_WIDTH-1:0] pend_w_q, pend_w_d;
  logic [7:0]           ovr_q, ovr_d;

  logic                 rise;
  logic                 inc;
  logic [DAC_WIDTH-1:0] launch_word;

  always_comb begin
    state_d  = state_q;
    strobe_d = DACStrobe;
    shreg_d  = shreg_q;
    half_d   = half_q;
    bit_d    = bit_q;
    lat_d    = lat_q;
    sclk_d   = sclk_q;
    sdi_d    = sdi_q;
    ncs_d    = ncs_q;
    nldac_d  = nldac_q;
    busy_d   = busy_q;
    pend_v_d = pend_v_q;
    pend_w_d = pend_w_q;
    inc      = 1'b0;
    rise     = DACStrobe & ~strobe_q;

    launch_word = pend_v_q ? pend_w_q : Yis;
`ifdef DAC714_OFFSET_BINARY_EN
    launch_word[DAC_WIDTH-1] = ~launch_word[DAC_WIDTH-1];
`endif

    case (state_q)
      S_IDLE: begin
        if (rise || pend_v_q) begin
          shreg_d = launch_word;
          sdi_d   = launch_word[DAC_WIDTH-1];
          ncs_d   = 1'b0;
          busy_d  = 1'b1;
          half_d  = '0;
          bit_d   = BW'(DAC_WIDTH);
          state_d = S_LOAD;
          // Pending word goes out first; a simultaneous rise refills the now-empty slot.
          if (pend_v_q) begin
            pend_v_d = rise;
            if (rise) pend_w_d = Yis;
          end
        end
      end
      S_LOAD: begin
        if (half_q == HW'(CLK_DIV - 1)) begin
          half_d  = '0;
          sclk_d  = 1'b1;
          state_d = S_SHIFT;
        end else begin
          half_d = half_q + 1'b1;
        end
      end
      S_SHIFT: begin
        if (half_q != HW'(CLK_DIV - 1)) begin
          half_d = half_q + 1'b1;
        end else begin
          half_d = '0;
          if (sclk_q) begin
            sclk_d  = 1'b0;
            shreg_d = shreg_q << 1;
            sdi_d   = shreg_q[DAC_WIDTH-2];
            bit_d   = bit_q - 1'b1;
          end else if (bit_q == '0) begin
            ncs_d   = 1'b1;
            nldac_d = 1'b0;
            lat_d   = '0;
            state_d = S_LATCH;
          end else begin
            sclk_d = 1'b1;
          end
        end
      end
      S_LATCH: begin
        if (lat_q == LW'(LATCH_CYC - 1)) begin
          nldac_d = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (rise && state_q != S_IDLE) begin
      pend_w_d = Yis;
      if (pend_v_q) inc = 1'b1;
      else          pend_v_d = 1'b1;
    end

    ovr_d = ovr_q;
    if (clr_overrun)              ovr_d = '0;
    else if (inc && ovr_q != '1)  ovr_d = ovr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q  <= S_IDLE;
      strobe_q <= 1'b0;
      shreg_q  <= '0;
      half_q   <= '0;
      bit_q    <= '0;
      lat_q    <= '0;
      sclk_q   <= 1'b0;
      sdi_q    <= 1'b0;
      ncs_q    <= 1'b1;
      nldac_q  <= 1'b1;
      busy_q   <= 1'b0;
      pend_v_q <= 1'b0;
      pend_w_q <= '0;
      ovr_q    <= '0;
    end else begin
      state_q  <= state_d;
      strobe_q <= strobe_d;
      shreg_q  <= shreg_d;
      half_q   <= half_d;
      bit_q    <= bit_d;
      lat_q    <= lat_d;
      sclk_q   <= sclk_d;
      sdi_q    <= sdi_d;
      ncs_q    <= ncs_d;
      nldac_q  <= nldac_d;
      busy_q   <= busy_d;
      pend_v_q <= pend_v_d;
      pend_w_q <= pend_w_d;
      ovr_q    <= ovr_d;
    end
  end

  assign dac_sclk    = sclk_q;
  assign dac_sdi     = sdi_q;
  assign dac_nCS     = ncs_q;
  assign dac_nLDAC   = nldac_q;
  assign busy        = busy_q;
  assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_dac714_serial_tx.sv
// Directed self-checking bench for dac714_serial_tx; a negedge monitor decodes frames off the DAC pins.
module tb_dac714_serial_tx;

  logic        clk = 1'b0;
  logic        nReset;
  logic        DACStrobe;
  logic [15:0] Yis;
  logic        clr_overrun;
  logic        dac_sclk, dac_sdi, dac_nCS, dac_nLDAC, busy;
  logic [7:0]  overrun_cnt;

  int compares = 0;
  int errors   = 0;

  always #5 clk = ~clk;

  dac714_serial_tx #(.DAC_WIDTH(16), .CLK_DIV(4), .LATCH_CYC(2)) dut (
    .clk(clk), .nReset(nReset), .DACStrobe(DACStrobe), .Yis(Yis),
    .clr_overrun(clr_overrun), .dac_sclk(dac_sclk), .dac_sdi(dac_sdi),
    .dac_nCS(dac_nCS), .dac_nLDAC(dac_nLDAC), .busy(busy), .overrun_cnt(overrun_cnt)
  );

  // Pin monitor: frames recorded at nCS release, pulse widths counted in clk cycles.
  logic        sclk_p = 1'b0, ncs_p = 1'b1, ldac_p = 1'b1, busy_p = 1'b0;
  logic [15:0] cap = '0;
  int          bits = 0, cyc = 0, fr_n = 0, ldac_n = 0;
  int          busy_run = 0, busy_len = 0, ldac_run = 0, ldac_len = 0;
  logic [15:0] fr_word [64];
  int          fr_bits [64];
  int          ncs_fall_cyc [64];
  int          ldac_rise_cyc [64];

  always @(negedge clk) begin
    cyc    <= cyc + 1;
    sclk_p <= dac_sclk;
    ncs_p  <= dac_nCS;
    ldac_p <= dac_nLDAC;
    busy_p <= busy;
    if (ncs_p && !dac_nCS) begin
      cap  <= '0;
      bits <= 0;
      ncs_fall_cyc[fr_n & 63] <= cyc;
    end else if (!sclk_p && dac_sclk && !dac_nCS) begin
      cap  <= {cap[14:0], dac_sdi};
      bits <= bits + 1;
    end
    if (!ncs_p && dac_nCS) begin
      fr_word[fr_n & 63] <= cap;
      fr_bits[fr_n & 63] <= bits;
      fr_n <= fr_n + 1;
    end
    if (busy) busy_run <= busy_run + 1;
    else if (busy_p) begin busy_len <= busy_run; busy_run <= 0; end
    if (!dac_nLDAC) ldac_run <= ldac_run + 1;
    else if (!ldac_p) begin
      ldac_len <= ldac_run;
      ldac_run <= 0;
      ldac_rise_cyc[ldac_n & 63] <= cyc;
      ldac_n <= ldac_n + 1;
    end
  end

  function automatic logic [15:0] expw(input logic [15:0] w);
`ifdef DAC714_OFFSET_BINARY_EN
    return w ^ 16'h8000;
`else
    return w;
`endif
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic strobe_pulse(input logic [15:0] w);
    Yis = w;
    DACStrobe = 1'b1;
    tick();
    DACStrobe = 1'b0;
    tick();
  endtask

  task automatic wait_quiet(input int budget, input string tag);
    int q = 0;
    int n = 0;
    while (q < 6 && n < budget) begin
      tick();
      n++;
      if (!busy) q++; else q = 0;
    end
    compares++;
    if (q < 6) begin
      errors++;
      $display("FAIL %s_timeout: busy still %b after %0d cycles, required 0", tag, busy, n);
    end
  endtask

  task automatic test_reset();
    nReset = 1'b0; DACStrobe = 1'b0; Yis = '0; clr_overrun = 1'b0;
    repeat (3) tick();
    compares += 6;
    if (dac_sclk !== 1'b0)      begin errors++; $display("FAIL rst_sclk: got %b want 0", dac_sclk); end
    if (dac_sdi !== 1'b0)       begin errors++; $display("FAIL rst_sdi: got %b want 0", dac_sdi); end
    if (dac_nCS !== 1'b1)       begin errors++; $display("FAIL rst_ncs: got %b want 1", dac_nCS); end
    if (dac_nLDAC !== 1'b1)     begin errors++; $display("FAIL rst_nldac: got %b want 1", dac_nLDAC); end
    if (busy !== 1'b0)          begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    if (overrun_cnt !== 8'h00)  begin errors++; $display("FAIL rst_ovr: got %h want 00", overrun_cnt); end
    nReset = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_single_frame();
    int fb = fr_n;
    int lb = ldac_n;
    strobe_pulse(16'h8001);
    wait_quiet(400, "single");
    compares += 5;
    if (fr_n - fb !== 1)           begin errors++; $display("FAIL single_frames: got %0d want 1", fr_n - fb); end
    if (fr_word[fb & 63] !== expw(16'h8001)) begin errors++; $display("FAIL single_word: got %h want %h", fr_word[fb & 63], expw(16'h8001)); end
    if (fr_bits[fb & 63] !== 16)   begin errors++; $display("FAIL single_bits: got %0d want 16", fr_bits[fb & 63]); end
    if (ldac_n - lb !== 1 || ldac_len !== 2) begin errors++; $display("FAIL single_ldac: got %0d pulses len %0d want 1 len 2", ldac_n - lb, ldac_len); end
    if (busy_len !== 134)          begin errors++; $display("FAIL single_busy: got %0d want 134", busy_len); end
  endtask

  task automatic test_level_hold();
    int fb = fr_n;
    Yis = 16'h1234;
    DACStrobe = 1'b1;
    repeat (500) tick();
    DACStrobe = 1'b0;
    wait_quiet(400, "level");
    compares += 2;
    if (fr_n - fb !== 1)        begin errors++; $display("FAIL level_frames: got %0d want 1", fr_n - fb); end
    if (overrun_cnt !== 8'h00)  begin errors++; $display("FAIL level_ovr: got %h want 00", overrun_cnt); end
  endtask

  task automatic test_back_to_back();
    int fb = fr_n;
    int lb = ldac_n;
    strobe_pulse(16'h3C5A);
    repeat (20) tick();
    strobe_pulse(16'h1111);
    repeat (20) tick();
    strobe_pulse(16'hC3A5);
    wait_quiet(600, "b2b");
    compares += 4;
    if (fr_n - fb !== 2)        begin errors++; $display("FAIL b2b_frames: got %0d want 2", fr_n - fb); end
    if (fr_word[fb & 63] !== expw(16'h3C5A) || fr_word[(fb + 1) & 63] !== expw(16'hC3A5))
      begin errors++; $display("FAIL b2b_words: got %h,%h want %h,%h", fr_word[fb & 63], fr_word[(fb + 1) & 63], expw(16'h3C5A), expw(16'hC3A5)); end
    if (overrun_cnt !== 8'h01)  begin errors++; $display("FAIL b2b_ovr: got %h want 01", overrun_cnt); end
    if (ncs_fall_cyc[(fb + 1) & 63] - ldac_rise_cyc[lb & 63] !== 1)
      begin errors++; $display("FAIL b2b_gap: got %0d want 1", ncs_fall_cyc[(fb + 1) & 63] - ldac_rise_cyc[lb & 63]); end
  endtask

  task automatic test_overrun_sat();
    for (int i = 0; i < 400; i++) strobe_pulse(16'(i));
    compares++;
    if (overrun_cnt !== 8'hFF) begin errors++; $display("FAIL sat_ovr: got %h want ff", overrun_cnt); end
    Yis = 16'h7777;
    DACStrobe = 1'b1;
    clr_overrun = 1'b1;
    tick();
    DACStrobe = 1'b0;
    clr_overrun = 1'b0;
    compares++;
    if (overrun_cnt !== 8'h00) begin errors++; $display("FAIL clr_wins: got %h want 00", overrun_cnt); end
    wait_quiet(1000, "sat");
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    compares++;
    if (overrun_cnt !== 8'h00) begin errors++; $display("FAIL clr_idle: got %h want 00", overrun_cnt); end
  endtask

  task automatic test_reset_midframe();
    int lb;
    int n = 0;
    int fb;
    strobe_pulse(16'hFFFF);
    while (bits < 7 && n < 300) begin tick(); n++; end
    compares++;
    if (bits < 7) begin errors++; $display("FAIL mid_reach_bit7: got %0d bits want 7", bits); end
    lb = ldac_n;
    #2 nReset = 1'b0;
    #1;
    compares += 3;
    if (dac_nCS !== 1'b1)   begin errors++; $display("FAIL mid_ncs: got %b want 1", dac_nCS); end
    if (dac_sclk !== 1'b0)  begin errors++; $display("FAIL mid_sclk: got %b want 0", dac_sclk); end
    if (busy !== 1'b0)      begin errors++; $display("FAIL mid_busy: got %b want 0", busy); end
    repeat (3) tick();
    nReset = 1'b1;
    repeat (10) tick();
    compares++;
    if (ldac_n !== lb)      begin errors++; $display("FAIL mid_no_ldac: got %0d pulses want 0", ldac_n - lb); end
    fb = fr_n;
    strobe_pulse(16'h5A5A);
    wait_quiet(400, "mid");
    compares++;
    if (fr_word[fb & 63] !== expw(16'h5A5A) || fr_bits[fb & 63] !== 16 || ldac_n - lb !== 1)
      begin errors++; $display("FAIL mid_clean: got %h/%0d bits/%0d pulses want %h/16/1", fr_word[fb & 63], fr_bits[fb & 63], ldac_n - lb, expw(16'h5A5A)); end
  endtask

  task automatic test_offset_binary();
    int fb = fr_n;
    logic [15:0] want;
`ifdef DAC714_OFFSET_BINARY_EN
    want = 16'h8000;
`else
    want = 16'h0000;
`endif
    strobe_pulse(16'h0000);
    wait_quiet(400, "offset");
    compares++;
    if (fr_word[fb & 63] !== want) begin errors++; $display("FAIL offset_word: got %h want %h", fr_word[fb & 63], want); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_level_hold();
    test_back_to_back();
    test_overrun_sat();
    test_reset_midframe();
    test_offset_binary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errors);
    $finish;
  end

endmodule
